// File: rtl/fully_pipelined_subtractor.sv
// fully_pipelined_subtractor: bit-sliced, fully pipelined WIDTH-bit subtractor with borrow and valid sideband
module fully_pipelined_subtractor #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             en,
    input  logic             valid_in,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             valid_out
);
    genvar k;
    for (k = 0; k < WIDTH; k++) begin : g_stg
        logic       a_bit, b_bit, brw_in, vld_in;
        logic [k:0] d_d, d_q;
        logic       br_d, br_q, v_q;
        if (k == 0) begin : g_src
            assign a_bit  = a[0];
            assign b_bit  = b[0];
            assign brw_in = bin;
            assign vld_in = valid_in;
            assign d_d    = a_bit ^ b_bit ^ brw_in;
        end else begin : g_src
            assign a_bit  = g_stg[k-1].g_up.a_q[0];
            assign b_bit  = g_stg[k-1].g_up.b_q[0];
            assign brw_in = g_stg[k-1].br_q;
            assign vld_in = g_stg[k-1].v_q;
            assign d_d    = {a_bit ^ b_bit ^ brw_in, g_stg[k-1].d_q};
        end
        assign br_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & brw_in);
        // Stage k result: difference bits resolved so far, outgoing borrow and valid
        always_ff @(posedge clk) begin
            if (rst) begin
                d_q  <= '0;
                br_q <= 1'b0;
                v_q  <= 1'b0;
            end else if (en) begin
                d_q  <= d_d;
                br_q <= br_d;
                v_q  <= vld_in;
            end
        end
        if (k < WIDTH - 1) begin : g_up
            logic [WIDTH-2-k:0] a_d, b_d, a_q, b_q;
            if (k == 0) begin : g_in
                assign a_d = a[WIDTH-1:1];
                assign b_d = b[WIDTH-1:1];
            end else begin : g_in
                assign a_d = g_stg[k-1].g_up.a_q[WIDTH-1-k:1];
                assign b_d = g_stg[k-1].g_up.b_q[WIDTH-1-k:1];
            end
            // Skew: operand bits not yet consumed travel down to their stage, LSB-aligned
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end
    assign d         = g_stg[WIDTH-1].d_q;
    assign bout      = g_stg[WIDTH-1].br_q;
    assign valid_out = g_stg[WIDTH-1].v_q;
endmodule

// File: tb/tb_fully_pipelined_subtractor.sv
// tb_fully_pipelined_subtractor: directed checks on WIDTH=3 and WIDTH=8 instances
module tb_fully_pipelined_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] a3, b3, d3;
    logic       bin3, en3, vin3, bout3, vout3;
    logic [7:0] a8, b8, d8;
    logic       bin8, en8, vin8, bout8, vout8;
    int         checks = 0;
    int         errors = 0;
    int         got8 = 0;
    int         issued8 = 0;
    logic [8:0] q8[$];

    always #5 clk = ~clk;

    fully_pipelined_subtractor #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .a(a3), .b(b3), .bin(bin3), .en(en3), .valid_in(vin3),
        .d(d3), .bout(bout3), .valid_out(vout3)
    );

    fully_pipelined_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .bin(bin8), .en(en8), .valid_in(vin8),
        .d(d8), .bout(bout8), .valid_out(vout8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set3(input logic [2:0] a, input logic [2:0] b, input logic bi, input logic v);
        a3 = a;
        b3 = b;
        bin3 = bi;
        vin3 = v;
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic bi,
                        input logic [2:0] ed, input logic eb, input string tag);
        set3(a, b, bi, 1'b1);
        tick;
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        tick;
        chk({tag, "_early"}, vout3, 0);
        tick;
        chk({tag, "_d"}, d3, ed);
        chk({tag, "_bout"}, bout3, eb);
        chk({tag, "_vld"}, vout3, 1);
    endtask

    task automatic cyc8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic e, input logic v, input logic [8:0] exp);
        a8 = a;
        b8 = b;
        bin8 = bi;
        en8 = e;
        vin8 = v;
        if (e && v) begin
            q8.push_back(exp);
            issued8++;
        end
        tick;
        if (e && vout8) begin
            got8++;
            chk("w8_expected", q8.size() > 0, 1);
            if (q8.size() > 0) chk("w8_result", {bout8, d8}, q8.pop_front());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ra, rb;
        logic       rbi;
        logic [8:0] t;
        rst = 1'b1;
        en3 = 1'b1;
        set3(3'd5, 3'd1, 1'b0, 1'b1);
        a8 = 8'd0; b8 = 8'd0; bin8 = 1'b0; en8 = 1'b1; vin8 = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        chk("rst_d3", d3, 0);
        chk("rst_bout3", bout3, 0);
        chk("rst_vld3", vout3, 0);
        chk("rst_d8", d8, 0);
        chk("rst_vld8", vout8, 0);
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        tick;
        tick;
        tick;
        chk("idle_vld3", vout3, 0);

        run3(3'd4, 3'd2, 1'b1, 3'd1, 1'b0, "basic_4_2_1");
        tick;
        chk("basic_vld_drop", vout3, 0);
        run3(3'd3, 3'd7, 1'b1, 3'd3, 1'b1, "basic_3_7_1");
        run3(3'd7, 3'd7, 1'b0, 3'd0, 1'b0, "max_max_0");
        run3(3'd0, 3'd0, 1'b1, 3'd7, 1'b1, "wrap_0_0_1");
        run3(3'd0, 3'd7, 1'b1, 3'd0, 1'b1, "ripple_0_7_1");

        set3(3'd4, 3'd2, 1'b1, 1'b1);
        tick;
        set3(3'd3, 3'd7, 1'b1, 1'b1);
        tick;
        set3(3'd7, 3'd7, 1'b0, 1'b1);
        tick;
        chk("strm1_d", d3, 1);
        chk("strm1_bout", bout3, 0);
        chk("strm1_vld", vout3, 1);
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        tick;
        chk("strm2_d", d3, 3);
        chk("strm2_bout", bout3, 1);
        chk("strm2_vld", vout3, 1);
        tick;
        chk("strm3_d", d3, 0);
        chk("strm3_bout", bout3, 0);
        chk("strm3_vld", vout3, 1);
        tick;
        chk("strm_end_vld", vout3, 0);

        set3(3'd0, 3'd0, 1'b1, 1'b1);
        tick;
        set3(3'd4, 3'd2, 1'b1, 1'b1);
        tick;
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        tick;
        chk("stall_pre_d", d3, 7);
        chk("stall_pre_bout", bout3, 1);
        chk("stall_pre_vld", vout3, 1);
        en3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set3(3'd5, 3'd1, 1'b0, 1'b1);
            tick;
            chk("stall_hold_d", d3, 7);
            chk("stall_hold_bout", bout3, 1);
            chk("stall_hold_vld", vout3, 1);
        end
        en3 = 1'b1;
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        tick;
        chk("stall_res_d", d3, 1);
        chk("stall_res_bout", bout3, 0);
        chk("stall_res_vld", vout3, 1);
        tick;
        chk("stall_ignored_vld", vout3, 0);
        chk("stall_ignored_d", d3, 0);

        set3(3'd0, 3'd0, 1'b1, 1'b1);
        tick;
        set3(3'd4, 3'd2, 1'b1, 1'b1);
        tick;
        set3(3'd3, 3'd7, 1'b1, 1'b1);
        tick;
        chk("flush_pre_d", d3, 7);
        chk("flush_pre_vld", vout3, 1);
        rst = 1'b1;
        set3(3'd7, 3'd1, 1'b0, 1'b1);
        tick;
        rst = 1'b0;
        chk("flush_d", d3, 0);
        chk("flush_bout", bout3, 0);
        chk("flush_vld", vout3, 0);
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("flush_no_result", vout3, 0);
        end
        run3(3'd7, 3'd1, 1'b0, 3'd6, 1'b0, "post_flush");

        set3(3'd4, 3'd2, 1'b1, 1'b1);
        tick;
        set3(3'd0, 3'd0, 1'b0, 1'b0);
        tick;
        en3 = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rst_en0_d", d3, 0);
        chk("rst_en0_vld", vout3, 0);
        en3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_en0_no_result", vout3, 0);
        end

        cyc8(8'd200, 8'd100, 1'b1, 1'b1, 1'b1, {1'b0, 8'd99});
        cyc8(8'd5,   8'd10,  1'b0, 1'b1, 1'b1, {1'b1, 8'd251});
        cyc8(8'd0,   8'd0,   1'b1, 1'b1, 1'b1, {1'b1, 8'd255});
        cyc8(8'd255, 8'd255, 1'b0, 1'b1, 1'b1, {1'b0, 8'd0});
        cyc8(8'd128, 8'd127, 1'b1, 1'b1, 1'b1, {1'b0, 8'd0});
        cyc8(8'd0,   8'd255, 1'b1, 1'b1, 1'b1, {1'b1, 8'd0});
        cyc8(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("w8_latency_early", got8, 0);
        cyc8(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("w8_latency_first", got8, 1);
        for (int i = 0; i < 6; i++) cyc8(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("w8_directed_count", got8, 6);

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rbi = 1'($urandom);
            t = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            cyc8(ra, rb, rbi, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7, t);
        end
        for (int i = 0; i < 12; i++) cyc8(8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("w8_total_count", got8, issued8);
        chk("w8_queue_empty", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fully_pipelined_subtractor.md
Name: fully_pipelined_subtractor

Overview:
- Bit-sliced, fully pipelined WIDTH-bit subtractor with borrow-in and borrow-out.
- Companion to fully_pipelined_adder: it performs the inverse operation on the same operand/enable interface style.
- Stage i resolves difference bit i and passes its borrow to stage i+1.
- Input skew and output deskew registers align all bits of one result, so a new operand pair is accepted every enabled cycle.
- Adds a valid sideband so downstream logic knows which outputs carry real results.

Parameters:
- WIDTH, 3, operand and result width in bits, also the pipeline depth. Legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in, subtracted from the LSB.
- en  input  1  pipeline advance enable. 0 freezes every register.
- valid_in  input  1  the operands on a/b/bin are real data.
- d  output  WIDTH  difference, registered.
- bout  output  1  borrow-out, registered.
- valid_out  output  1  d/bout hold a real result, registered.

Behaviour:
- Arithmetic: d = (a - b - bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin (unsigned compare).
  - Invariant: a - b - bin = d - bout*2^WIDTH.
- Stage k (0..WIDTH-1):
  - d_k = a_k ^ b_k ^ borrow_k.
  - borrow_{k+1} = (~a_k & b_k) | (~(a_k ^ b_k) & borrow_k).
  - borrow_0 = bin.
  - bout = borrow_WIDTH.
- Skew: bits above k travel through k delay registers before reaching stage k. Computed low bits travel through deskew registers so all WIDTH bits arrive at d together.
- Latency: operands sampled on an enabled edge E appear on d/bout/valid_out after the (WIDTH-1)th further enabled edge, i.e. WIDTH enabled edges counted including E. For WIDTH=3: sampled at edge 1, visible after edge 3.
- Throughput: one operation per enabled cycle. Back-to-back results appear on consecutive enabled cycles in issue order.
- valid_in is carried alongside the data through every stage. Data registers load regardless of valid; only valid_out qualifies outputs.
- en=0: no register changes anywhere, including the valid chain.
  - Outputs hold their values.
  - Inputs are ignored that cycle.
  - Latency is counted in enabled edges only.
- Reset (rst=1 at a rising edge):
  - All valid bits in the pipeline clear.
  - d, bout, and every skew/deskew/borrow register clear to 0.
  - valid_out=0 the cycle after reset.
  - rst overrides en, so reset applies even with en=0.
- Reset mid-operation: in-flight operations are discarded. No valid_out pulse occurs for them after reset releases. Operands presented in the same cycle as rst=1 are dropped.
- Boundaries:
  - 0 - 0 - 1 gives d = all ones, bout = 1.
  - max - max - 0 gives 0, bout = 0.
  - A full borrow ripple across all WIDTH stages must not add latency.
- No combinational path from any input to any output.

Test Plan:
- Basic, WIDTH=3, en=1:
  - a=4,b=2,bin=1 -> d=1, bout=0, valid_out=1 exactly 3 enabled edges after sampling.
  - a=3,b=7,bin=1 -> d=3, bout=1.
  - a=7,b=7,bin=0 -> d=0, bout=0.
- Wrap, WIDTH=3: a=0,b=0,bin=1 -> d=7, bout=1. a=0,b=7,bin=1 -> d=0, bout=1. Full borrow ripple with latency still 3.
- Streaming, WIDTH=3:
  - Issue (4,2,1), (3,7,1), (7,7,0) on consecutive edges with valid_in=1.
  - Results 1/0, 3/1, 0/0 on three consecutive cycles. valid_out is high only for those three cycles.
- Stall:
  - Issue (4,2,1), then hold en=0 for 5 cycles after the 2nd enabled edge.
  - d/bout/valid_out frozen during the stall. Result 1/0 appears on the 3rd enabled edge.
  - Inputs changed during the stall have no effect.
- Reset mid-flight:
  - Issue 2 ops, assert rst for 1 cycle before either emerges.
  - valid_out, d, bout read 0 the next cycle.
  - No result for the flushed ops is ever emitted. A new op issued after reset completes with normal latency.
- Random, WIDTH=8:
  - 1000 random a/b/bin with random en and valid_in.
  - Scoreboard checks each valid_out against (a-b-bin) mod 256 and the borrow rule, in order, with no drops or duplicates.
